regfile_sb: RTL and testbench

Parametrised multi-read-port register file with a per-register pending-write scoreboard and a sequenced clear engine. It is the next-generation general-purpose register file for the datapath. It stores NUM_REGS words of DATA_WIDTH bits. Reads are combinational with same-cycle write bypass. Each register carries a busy flag for in-flight writes, and a clear command zeroes the file one register per cycle.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/load_reg.sv | 20 ++
 rtl/regfile_sb.sv | 160 ++++++++++++++++
 tb/tb_regfile_sb.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and clear-engine state type for the datapath register file.
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_NUM_REGS   = 8;
    localparam int DEFAULT_NUM_RD     = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/load_reg.sv
// Plain loadable register with asynchronous active-high reset to zero.
module load_reg #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with a pending-write busy scoreboard and a
// one-register-per-cycle clear engine.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int NUM_REGS   = DEFAULT_NUM_REGS,
    parameter  int NUM_RD     = DEFAULT_NUM_RD,
    localparam int ADDR_W     = $clog2(NUM_REGS)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]       rd_addr,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]                   rd_busy,
    input  logic                                wr_en,
    input  logic [ADDR_W-1:0]                   wr_addr,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    input  logic                                rsv_en,
    input  logic [ADDR_W-1:0]                   rsv_addr,
    output logic                                rsv_ok,
    input  logic                                clr_start,
    output logic                                clr_busy
);

    clr_state_t              state;
    clr_state_t              state_next;
    logic [ADDR_W-1:0]       idx;
    logic [ADDR_W-1:0]       idx_next;
    logic                    idle;

    logic [NUM_REGS-1:0]     wr_hit;
    logic [NUM_REGS-1:0]     rsv_sel;
    logic [NUM_REGS-1:0]     rsv_hit;
    logic [NUM_REGS-1:0]     clr_hit;
    logic [NUM_REGS-1:0]     busy;
    logic [DATA_WIDTH-1:0]   reg_q [NUM_REGS];

    logic                    wr_live;
    logic                    rsv_busy;
    logic                    rsv_in_range;
    logic                    wr_same;

    assign idle     = (state == IDLE);
    assign clr_busy = (state == CLEAR);

    // Address decodes; an address beyond NUM_REGS-1 matches no register,
    // which is what makes out-of-range writes/reserves/reads inert.
    always_comb begin
        wr_hit  = '0;
        rsv_sel = '0;
        clr_hit = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (idle && wr_en && (wr_addr == ADDR_W'(r))) begin
                wr_hit[r] = 1'b1;
            end
            if (rsv_addr == ADDR_W'(r)) begin
                rsv_sel[r] = 1'b1;
            end
            if (clr_busy && (idx == ADDR_W'(r))) begin
                clr_hit[r] = 1'b1;
            end
        end
    end

    assign wr_live      = |wr_hit;
    assign rsv_in_range = |rsv_sel;
    assign rsv_busy     = |(busy & rsv_sel);
    assign wr_same      = wr_en && (wr_addr == rsv_addr);
    assign rsv_ok       = idle && rsv_in_range && (!rsv_busy || wr_same);
    assign rsv_hit      = rsv_sel & {NUM_REGS{rsv_en && rsv_ok}};

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        load_reg #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_reg (
            .clk   (clk),
            .reset (reset),
            .load  (wr_hit[r] | clr_hit[r]),
            .d     (clr_hit[r] ? '0 : wr_data),
            .q     (reg_q[r])
        );
    end

    // Reserve outranks a same-cycle write so the slot ends up busy again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (clr_hit[r]) begin
                    busy[r] <= 1'b0;
                end else if (rsv_hit[r]) begin
                    busy[r] <= 1'b1;
                end else if (wr_hit[r]) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [DATA_WIDTH-1:0] port_data;
        logic                  port_busy;

        always_comb begin
            port_data = '0;
            port_busy = 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (rd_addr[p] == ADDR_W'(r)) begin
                    port_data = reg_q[r];
                    port_busy = busy[r];
                end
            end
            if (wr_live && (wr_addr == rd_addr[p])) begin
                port_data = wr_data;
                port_busy = 1'b0;
            end
        end

        assign rd_data[p] = port_data;
        assign rd_busy[p] = port_busy;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_next = CLEAR;
                    idx_next   = '0;
                end
            end
            CLEAR: begin
                if (idx == ADDR_W'(NUM_REGS - 1)) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + ADDR_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: an 8x16/2-port and a 6x16/3-port instance share stimulus
// and are both compared every cycle against a behavioural model.
module tb_regfile_sb;

    logic clk;
    logic reset;
    logic wr_en;
    logic [2:0] wr_addr;
    logic [15:0] wr_data;
    logic rsv_en;
    logic [2:0] rsv_addr;
    logic clr_start;

    logic [1:0][2:0]  rd_addr_a;
    logic [1:0][15:0] rd_data_a;
    logic [1:0]       rd_busy_a;
    logic             rsv_ok_a;
    logic             clr_busy_a;

    logic [2:0][2:0]  rd_addr_b;
    logic [2:0][15:0] rd_data_b;
    logic [2:0]       rd_busy_b;
    logic             rsv_ok_b;
    logic             clr_busy_b;

    int checks = 0;
    int passes = 0;

    logic [15:0] mdata [2][8];
    logic        mbusy [2][8];
    logic        mclr  [2];
    int          midx  [2];

    typedef struct {
        logic        wr_en;
        logic [2:0]  wr_addr;
        logic [15:0] wr_data;
        logic        rsv_en;
        logic [2:0]  rsv_addr;
        logic [2:0]  ra0;
        logic [2:0]  ra1;
        logic [15:0] ed0;
        logic        eb0;
        logic [15:0] ed1;
        logic        eb1;
        logic        eok;
        logic        eclr;
    } vec_t;

    vec_t tbl [9];

    regfile_sb #(.DATA_WIDTH(16), .NUM_REGS(8), .NUM_RD(2)) dut_a (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok_a),
        .clr_start(clr_start), .clr_busy(clr_busy_a)
    );

    regfile_sb #(.DATA_WIDTH(16), .NUM_REGS(6), .NUM_RD(3)) dut_b (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok_b),
        .clr_start(clr_start), .clr_busy(clr_busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int regCount(input int m);
        return (m == 0) ? 8 : 6;
    endfunction

    function automatic logic [15:0] expData(input int m, input logic [2:0] a);
        if (int'(a) >= regCount(m)) return 16'h0000;
        if (!mclr[m] && wr_en && (wr_addr == a)) return wr_data;
        return mdata[m][a];
    endfunction

    function automatic logic expBusy(input int m, input logic [2:0] a);
        if (int'(a) >= regCount(m)) return 1'b0;
        if (!mclr[m] && wr_en && (wr_addr == a)) return 1'b0;
        return mbusy[m][a];
    endfunction

    function automatic logic expRsvOk(input int m);
        if (mclr[m]) return 1'b0;
        if (int'(rsv_addr) >= regCount(m)) return 1'b0;
        return !mbusy[m][rsv_addr] || (wr_en && (wr_addr == rsv_addr));
    endfunction

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            for (int r = 0; r < 8; r++) begin
                mdata[m][r] = 16'h0000;
                mbusy[m][r] = 1'b0;
            end
            mclr[m] = 1'b0;
            midx[m] = 0;
        end
    endtask

    task automatic modelEdge();
        bit ok;
        for (int m = 0; m < 2; m++) begin
            if (mclr[m]) begin
                mdata[m][midx[m]] = 16'h0000;
                mbusy[m][midx[m]] = 1'b0;
                midx[m] = midx[m] + 1;
                if (midx[m] == regCount(m)) mclr[m] = 1'b0;
            end else begin
                ok = expRsvOk(m);
                if (wr_en && (int'(wr_addr) < regCount(m))) begin
                    mdata[m][wr_addr] = wr_data;
                    mbusy[m][wr_addr] = 1'b0;
                end
                if (rsv_en && ok) mbusy[m][rsv_addr] = 1'b1;
                if (clr_start) begin
                    mclr[m] = 1'b1;
                    midx[m] = 0;
                end
            end
        end
    endtask

    task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic checkOutput();
        for (int p = 0; p < 2; p++) begin
            checkVal($sformatf("a.rd_data[%0d]", p), rd_data_a[p], expData(0, rd_addr_a[p]));
            checkVal($sformatf("a.rd_busy[%0d]", p), 16'(rd_busy_a[p]), 16'(expBusy(0, rd_addr_a[p])));
        end
        checkVal("a.rsv_ok", 16'(rsv_ok_a), 16'(expRsvOk(0)));
        checkVal("a.clr_busy", 16'(clr_busy_a), 16'(mclr[0]));
        for (int p = 0; p < 3; p++) begin
            checkVal($sformatf("b.rd_data[%0d]", p), rd_data_b[p], expData(1, rd_addr_b[p]));
            checkVal($sformatf("b.rd_busy[%0d]", p), 16'(rd_busy_b[p]), 16'(expBusy(1, rd_addr_b[p])));
        end
        checkVal("b.rsv_ok", 16'(rsv_ok_b), 16'(expRsvOk(1)));
        checkVal("b.clr_busy", 16'(clr_busy_b), 16'(mclr[1]));
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                                 input logic re, input logic [2:0] ra, input logic cs);
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        rsv_en    = re;
        rsv_addr  = ra;
        clr_start = cs;
        #3;
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic setReads(input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2);
        rd_addr_a[0] = a0;
        rd_addr_a[1] = a1;
        rd_addr_b[0] = a0;
        rd_addr_b[1] = a1;
        rd_addr_b[2] = a2;
    endtask

    initial begin
        tbl[0] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd3, 3'd3, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd3, 3'd3, 3'd5, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd3, 3'd3, 3'd3, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd3, 3'd3, 3'd0, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd5, 3'd3, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 3'd5, 16'h0012, 1'b1, 3'd5, 3'd5, 3'd5, 16'h0012, 1'b0, 16'h0012, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd5, 3'd5, 3'd3, 16'h0012, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 3'd5, 16'h00A5, 1'b0, 3'd5, 3'd5, 3'd2, 16'h00A5, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd5, 3'd5, 3'd3, 16'h00A5, 1'b0, 16'hBEEF, 1'b0, 1'b1, 1'b0};

        reset = 1'b1;
        setReads(3'd0, 3'd0, 3'd0);
        wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0000;
        rsv_en = 1'b0; rsv_addr = 3'd0; clr_start = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput();
        reset = 1'b0;

        // Reset state: every address empty, idle, reservable.
        for (int a = 0; a < 8; a++) begin
            setReads(3'(a), 3'(7 - a), 3'(a));
            applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'(a), 1'b0);
            checkOutput();
            checkVal("p1.rd_data0", rd_data_a[0], 16'h0000);
            checkVal("p1.rd_busy1", 16'(rd_busy_a[1]), 16'h0000);
            checkVal("p1.rsv_ok", 16'(rsv_ok_a), 16'h0001);
            checkVal("p1.clr_busy", 16'(clr_busy_a), 16'h0000);
            tick();
        end

        // Reserve, bypass and write-plus-reserve vectors.
        for (int i = 0; i < 9; i++) begin
            setReads(tbl[i].ra0, tbl[i].ra1, 3'(i));
            applyStimulus(tbl[i].wr_en, tbl[i].wr_addr, tbl[i].wr_data,
                          tbl[i].rsv_en, tbl[i].rsv_addr, 1'b0);
            checkOutput();
            checkVal($sformatf("tbl[%0d].rd_data0", i), rd_data_a[0], tbl[i].ed0);
            checkVal($sformatf("tbl[%0d].rd_busy0", i), 16'(rd_busy_a[0]), 16'(tbl[i].eb0));
            checkVal($sformatf("tbl[%0d].rd_data1", i), rd_data_a[1], tbl[i].ed1);
            checkVal($sformatf("tbl[%0d].rd_busy1", i), 16'(rd_busy_a[1]), 16'(tbl[i].eb1));
            checkVal($sformatf("tbl[%0d].rsv_ok", i), 16'(rsv_ok_a), 16'(tbl[i].eok));
            checkVal($sformatf("tbl[%0d].clr_busy", i), 16'(clr_busy_a), 16'(tbl[i].eclr));
            tick();
        end

        // Fill, then clear sequence with ignored write/reserve/restart inside.
        for (int i = 0; i < 8; i++) begin
            setReads(3'(i), 3'd0, 3'd0);
            applyStimulus(1'b1, 3'(i), 16'(16'h1111 * (i + 1)), 1'b0, 3'd0, 1'b0);
            checkOutput();
            tick();
        end
        setReads(3'd0, 3'd7, 3'd1);
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1);
        checkOutput();
        checkVal("p4.clr_busy_pre", 16'(clr_busy_a), 16'h0000);
        tick();
        for (int c = 0; c < 8; c++) begin
            setReads(3'(c), (c == 0) ? 3'd7 : 3'(c - 1), 3'(c));
            applyStimulus(c == 2, 3'd7, 16'hFFFF, c == 3, 3'd1, c == 4);
            checkOutput();
            checkVal($sformatf("p4.clr_busy[%0d]", c), 16'(clr_busy_a), 16'h0001);
            checkVal($sformatf("p4.rsv_ok[%0d]", c), 16'(rsv_ok_a), 16'h0000);
            checkVal($sformatf("p4.pending[%0d]", c), rd_data_a[0], 16'(16'h1111 * (c + 1)));
            checkVal($sformatf("p4.cleared[%0d]", c), rd_data_a[1], (c == 0) ? 16'h8888 : 16'h0000);
            tick();
        end
        setReads(3'd1, 3'd7, 3'd0);
        applyStimulus(1'b1, 3'd1, 16'h1234, 1'b0, 3'd0, 1'b0);
        checkOutput();
        checkVal("p4.clr_busy_post", 16'(clr_busy_a), 16'h0000);
        checkVal("p4.bypass_after_clear", rd_data_a[0], 16'h1234);
        checkVal("p4.ignored_write", rd_data_a[1], 16'h0000);
        tick();
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd1, 1'b0);
        checkOutput();
        checkVal("p4.write_after_clear", rd_data_a[0], 16'h1234);
        checkVal("p4.ignored_reserve", 16'(rd_busy_a[0]), 16'h0000);
        tick();

        // Reset arriving in the third clear cycle.
        setReads(3'd2, 3'd6, 3'd2);
        applyStimulus(1'b1, 3'd2, 16'h2222, 1'b0, 3'd0, 1'b0);
        checkOutput();
        tick();
        applyStimulus(1'b1, 3'd6, 16'h6666, 1'b0, 3'd0, 1'b0);
        checkOutput();
        tick();
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1);
        checkOutput();
        tick();
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0);
            checkOutput();
            tick();
        end
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0);
        checkOutput();
        checkVal("p5.pre_reset_r2", rd_data_a[0], 16'h2222);
        checkVal("p5.pre_reset_busy", 16'(clr_busy_a), 16'h0001);
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput();
        checkVal("p5.async_clr_busy", 16'(clr_busy_a), 16'h0000);
        checkVal("p5.async_r2", rd_data_a[0], 16'h0000);
        checkVal("p5.async_r6", rd_data_a[1], 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        setReads(3'd4, 3'd6, 3'd4);
        applyStimulus(1'b1, 3'd4, 16'h4444, 1'b0, 3'd0, 1'b0);
        checkOutput();
        tick();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0);
            checkOutput();
            checkVal($sformatf("p5.first_write[%0d]", c), rd_data_a[0], 16'h4444);
            checkVal($sformatf("p5.no_clear[%0d]", c), 16'(clr_busy_a), 16'h0000);
            tick();
        end

        // Six-register instance: out-of-range addresses and three distinct reads.
        setReads(3'd0, 3'd0, 3'd0);
        applyStimulus(1'b1, 3'd0, 16'hA0A0, 1'b0, 3'd0, 1'b0);
        checkOutput();
        tick();
        applyStimulus(1'b1, 3'd2, 16'hB2B2, 1'b0, 3'd0, 1'b0);
        checkOutput();
        tick();
        applyStimulus(1'b1, 3'd5, 16'hC5C5, 1'b0, 3'd0, 1'b0);
        checkOutput();
        tick();
        setReads(3'd5, 3'd2, 3'd0);
        applyStimulus(1'b1, 3'd6, 16'h6006, 1'b1, 3'd6, 1'b0);
        checkOutput();
        checkVal("p6.rsv_ok_oob", 16'(rsv_ok_b), 16'h0000);
        checkVal("p6.port0", rd_data_b[0], 16'hC5C5);
        checkVal("p6.port1", rd_data_b[1], 16'hB2B2);
        checkVal("p6.port2", rd_data_b[2], 16'hA0A0);
        tick();
        setReads(3'd7, 3'd6, 3'd5);
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd6, 1'b0);
        checkOutput();
        checkVal("p6.read7", rd_data_b[0], 16'h0000);
        checkVal("p6.read6", rd_data_b[1], 16'h0000);
        checkVal("p6.busy6", 16'(rd_busy_b[1]), 16'h0000);
        checkVal("p6.rsv_ok6", 16'(rsv_ok_b), 16'h0000);
        checkVal("p6.port2_again", rd_data_b[2], 16'hC5C5);
        tick();

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            setReads(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                          ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
                          ($urandom_range(0, 39) == 0));
            checkOutput();
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
